// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, types and digit helper for the display scan controller
package display_pkg;

    localparam int          DIGITS      = 4;
    localparam int          BCD_W       = 4;
    localparam logic [13:0] MAX_VALUE   = 14'd9999;
    localparam int          CONV_CYCLES = 14;
    localparam logic [3:0]  ANODE_RESET = 4'b1110;
    localparam logic [3:0]  BLANK_CODE  = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        LATCH
    } conv_state_t;

    typedef logic [BCD_W-1:0] bcd_t;

    // Double-dabble correction: a digit of 5 or more would carry past 9
    // after the next shift, so pre-add 3.
    function automatic bcd_t add3(input bcd_t d);
        return (d >= 4'd5) ? bcd_t'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 14-iteration double-dabble binary to BCD engine
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : load bin_in and begin a conversion (one cycle pulse)
//   bin_in       : 14-bit binary value, already clamped to 0..9999
//   done         : high during the final iteration cycle
//   bcd_out      : four BCD digits, thousands in [15:12], ones in [3:0];
//                  final once the cycle after done is reached
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [13:0] bin_in,
    output logic        done,
    output logic [15:0] bcd_out
);

    logic [13:0] bin_sr;
    logic [15:0] bcd_sr;
    logic [15:0] adj;
    logic [3:0]  iter;
    logic        active;

    always_comb begin
        adj = bcd_sr;
        for (int i = 0; i < DIGITS; i++) begin
            adj[i*BCD_W +: BCD_W] = add3(bcd_sr[i*BCD_W +: BCD_W]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_sr <= '0;
            bcd_sr <= '0;
            iter   <= '0;
            active <= 1'b0;
        end else if (start) begin
            bin_sr <= bin_in;
            bcd_sr <= '0;
            iter   <= '0;
            active <= 1'b1;
        end else if (active) begin
            // Shift the corrected BCD and the binary register left as one word.
            {bcd_sr, bin_sr} <= {adj[14:0], bin_sr, 1'b0};
            iter             <= iter + 4'd1;
            if (iter == 4'(CONV_CYCLES - 1)) begin
                active <= 1'b0;
            end
        end
    end

    assign done    = active && (iter == 4'(CONV_CYCLES - 1));
    assign bcd_out = bcd_sr;

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - valid/ready binary input, BCD conversion, 4-digit multiplexed scan
//
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank digits above the
// most significant nonzero digit; the ones digit always shows).
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   value_in     : binary value to display (values above 9999 clamp to 9999)
//   value_valid  : value_in valid this cycle
//   value_ready  : block can accept a value (IDLE)
//   busy         : conversion in progress
//   overflow     : last latched value exceeded 9999
//   digit_bcd    : BCD digit for the enabled position
//   digit_sel    : active-low one-hot digit enable, bit0 = ones
module display_scan_controller
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DATA_W   = 14
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] value_in,
    input  logic              value_valid,
    output logic              value_ready,
    output logic              busy,
    output logic              overflow,
    output logic [3:0]        digit_bcd,
    output logic [3:0]        digit_sel
);

    conv_state_t state, state_next;
    logic        accept;
    logic        latch_en;
    logic        conv_done;
    logic [13:0] clamped;
    logic [15:0] conv_bcd;
    logic        ovf_shadow;

    logic [15:0] disp, disp_next;
    logic [3:0]  blank_next;
    logic [15:0] scan_cnt;
    logic [1:0]  scan_idx, idx_next;
    logic        scan_wrap;
    logic [3:0]  sel_next;
    bcd_t        bcd_next;

    assign clamped = (value_in > DATA_W'(MAX_VALUE)) ? MAX_VALUE : value_in[13:0];

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (accept),
        .bin_in  (clamped),
        .done    (conv_done),
        .bcd_out (conv_bcd)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (value_valid) state_next = CONVERT;
            CONVERT: if (conv_done)   state_next = LATCH;
            LATCH:                    state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    always_comb begin
        value_ready = (state == IDLE);
        busy        = (state == CONVERT);
        latch_en    = (state == LATCH);
        accept      = value_ready && value_valid;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_shadow <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (accept)   ovf_shadow <= (value_in > DATA_W'(MAX_VALUE));
            if (latch_en) overflow   <= ovf_shadow;
        end
    end

    assign disp_next = latch_en ? conv_bcd : disp;

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] blank_q;

    always_comb begin
        blank_next = blank_q;
        if (latch_en) begin
            blank_next[3] = (conv_bcd[15:12] == 4'd0);
            blank_next[2] = blank_next[3] && (conv_bcd[11:8] == 4'd0);
            blank_next[1] = blank_next[2] && (conv_bcd[7:4] == 4'd0);
            blank_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_next;
        end
    end
`else
    assign blank_next = 4'b0000;
`endif

    assign scan_wrap = (scan_cnt == 16'(SCAN_DIV - 1));
    assign idx_next  = scan_wrap ? scan_idx + 2'd1 : scan_idx;

    // Outputs are built from next-cycle index and display contents so the
    // enable, the digit and a freshly latched value all change on one edge.
    always_comb begin
        sel_next = ~(4'b0001 << idx_next);
        bcd_next = disp_next[{idx_next, 2'b00} +: 4];
        if (blank_next[idx_next]) begin
            sel_next = 4'b1111;
            bcd_next = BLANK_CODE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp      <= '0;
            scan_cnt  <= '0;
            scan_idx  <= '0;
            digit_sel <= ANODE_RESET;
            digit_bcd <= '0;
        end else begin
            disp      <= disp_next;
            scan_cnt  <= scan_wrap ? 16'd0 : scan_cnt + 16'd1;
            scan_idx  <= idx_next;
            digit_sel <= sel_next;
            digit_bcd <= bcd_next;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - scoreboard bench for display_scan_controller
module tb_display_scan_controller;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [13:0] value_in = '0;
    logic        value_valid = 1'b0;
    logic        value_ready;
    logic        busy;
    logic        overflow;
    logic [3:0]  digit_bcd;
    logic [3:0]  digit_sel;

    display_scan_controller #(.SCAN_DIV(SCAN_DIV), .DATA_W(14)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .value_in    (value_in),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .busy        (busy),
        .overflow    (overflow),
        .digit_bcd   (digit_bcd),
        .digit_sel   (digit_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   k = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Edges since reset release; the scan index follows from it directly.
    always @(posedge clk) begin
        if (!reset_n) k <= 0;
        else          k <= k + 1;
    end

    // Monitor: each rise of value_ready marks a LATCH; the next expectation is
    // popped and checked over a full scan or until the following LATCH.
    initial begin
        logic       prev_ready;
        int         win;
        int         idx;
        exp_t       cur;
        logic       blank;
        logic [3:0] one;
        logic [3:0] exp_sel;
        logic [3:0] exp_bcd;
        prev_ready = 1'b1;
        win = 0;
        one = 4'b0001;
        cur = '{16'h0000, 1'b0};
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_ready = 1'b1;
                win = 0;
            end else begin
                if (value_ready && !prev_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_latch", 32'd1, 32'd0);
                        win = 0;
                    end else begin
                        cur = exp_q.pop_front();
                        win = 16;
                    end
                end
                if (win > 0) begin
                    idx = (k / SCAN_DIV) % 4;
`ifdef LEADING_ZERO_BLANK_EN
                    blank = (idx == 3 && cur.bcd[15:12] == 4'd0) ||
                            (idx == 2 && cur.bcd[15:8]  == 8'd0) ||
                            (idx == 1 && cur.bcd[15:4]  == 12'd0);
`else
                    blank = 1'b0;
`endif
                    exp_sel = blank ? 4'b1111 : ~(one << idx);
                    exp_bcd = blank ? 4'hF : cur.bcd[idx*4 +: 4];
                    check($sformatf("digit_sel[%0h]", cur.bcd), 32'(digit_sel), 32'(exp_sel));
                    check($sformatf("digit_bcd[%0h]", cur.bcd), 32'(digit_bcd), 32'(exp_bcd));
                    check($sformatf("overflow[%0h]", cur.bcd), 32'(overflow), 32'(cur.ovf));
                    win--;
                end
                prev_ready = value_ready;
            end
        end
    end

    task automatic send(input logic [13:0] v, input logic [15:0] eb, input logic eo, output int waited);
        @(negedge clk);
        value_in = v;
        value_valid = 1'b1;
        waited = 0;
        while (!value_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!value_ready) check("send_timeout", 32'd1, 32'd0);
        exp_q.push_back('{eb, eo});
        @(posedge clk);
        #1;
        value_valid = 1'b0;
    endtask

    task automatic wait_ready(output int low_cnt);
        @(negedge clk);
        low_cnt = 0;
        while (!value_ready && low_cnt < 100) begin
            low_cnt++;
            @(negedge clk);
        end
        if (!value_ready) check("ready_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_digit_sel"}, 32'(digit_sel), 32'h0000000E);
        check({tag, "_digit_bcd"}, 32'(digit_bcd), 32'd0);
        check({tag, "_value_ready"}, 32'(value_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        int w;
        int lc;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        send(14'd1234, 16'h1234, 1'b0, w);
        check("idle_accept_wait", 32'(w), 32'd0);
        wait_ready(lc);
        check("ready_low_1234", 32'(lc), 32'd15);
        repeat (20) @(negedge clk);

        send(14'd16383, 16'h9999, 1'b1, w);
        wait_ready(lc);
        repeat (20) @(negedge clk);
        send(14'd0, 16'h0000, 1'b0, w);
        wait_ready(lc);
        repeat (20) @(negedge clk);

        send(14'd16383, 16'h9999, 1'b1, w);
        wait_ready(lc);
        repeat (20) @(negedge clk);
        send(14'd4321, 16'h4321, 1'b0, w);
        repeat (3) @(negedge clk);
        check("busy_mid_conv", 32'(busy), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_values("mid");
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        send(14'd1234, 16'h1234, 1'b0, w);
        send(14'd5678, 16'h5678, 1'b0, w);
        check("held_accept_wait", 32'(w), 32'd15);
        wait_ready(lc);
        check("ready_low_5678", 32'(lc), 32'd15);
        repeat (20) @(negedge clk);

        send(14'd9999, 16'h9999, 1'b0, w);
        send(14'd1, 16'h0001, 1'b0, w);
        check("b2b_accept_wait", 32'(w), 32'd15);
        wait_ready(lc);
        repeat (20) @(negedge clk);

        send(14'd42, 16'h0042, 1'b0, w);
        wait_ready(lc);
        repeat (20) @(negedge clk);
        send(14'd0, 16'h0000, 1'b0, w);
        wait_ready(lc);
        repeat (20) @(negedge clk);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
